// File: rtl/mmcm_lock_supervisor.sv
// -----------------------------------------------------------------------------
// mmcm_lock_supervisor
//
// Supervises the board MMCM that produces the fabric clocks. The logic runs
// on the free-running board clock. It pulses the MMCM reset and waits for
// LOCKED, retrying on timeout. It holds the downstream system reset until
// lock has been stable for a full window. It counts lock losses seen while
// running. After repeated consecutive lock timeouts it latches a sticky fault.
//
// Optional build macro: LOCK_DEGLITCH_EN
//   When defined, a lock dropout in RUN must persist for DEGLITCH_CYCLES
//   consecutive cycles before it is acted on. When undefined, a single low
//   cycle of the synchronized lock triggers lock-loss handling.
//
// Ports:
//   clk_in          in   board clock, free-running, never from the MMCM
//   rst             in   synchronous active-high reset
//   locked_async    in   MMCM LOCKED, asynchronous to clk_in
//   mmcm_rst        out  MMCM RST request, active high
//   sys_rst         out  downstream system reset, active high
//   ready           out  high only while in RUN
//   fault           out  sticky fault, high in FAULT until rst
//   lock_loss_count out  [7:0] lock losses detected in RUN, saturating
//   retry_count     out  [2:0] consecutive lock timeouts since last lock
// -----------------------------------------------------------------------------
module mmcm_lock_supervisor #(
  parameter int SYNC_STAGES     = 2,
  parameter int RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT    = 125000,
  parameter int STABLE_CYCLES   = 1024,
  parameter int MAX_RETRIES     = 4,
  parameter int DEGLITCH_CYCLES = 8
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       locked_async,
  output logic       mmcm_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] lock_loss_count,
  output logic [2:0] retry_count
);

  // One shared counter. It is sized for the longest interval any state can time.
  localparam int CNT_MAX_A = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int CNT_MAX_B = (RST_CYCLES > DEGLITCH_CYCLES) ? RST_CYCLES : DEGLITCH_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [2:0]       RETRY_LIMIT  = 3'(MAX_RETRIES);
`ifdef LOCK_DEGLITCH_EN
  localparam logic [CNT_W-1:0] DG_LAST      = CNT_W'(DEGLITCH_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ST_RESET_MMCM = 3'd0,
    ST_WAIT_LOCK  = 3'd1,
    ST_STABILIZE  = 3'd2,
    ST_RUN        = 3'd3,
    ST_FAULT      = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic [2:0]             retry_q, retry_d;
  logic [7:0]             loss_q, loss_d;
  logic                   mmcm_rst_q, mmcm_rst_d;
  logic                   sys_rst_q, sys_rst_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;

  // Saturating increment for the 8-bit lock-loss counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return v;
    end else begin
      return v + 8'd1;
    end
  endfunction

  assign lock_s          = sync_q[SYNC_STAGES-1];
  assign mmcm_rst        = mmcm_rst_q;
  assign sys_rst         = sys_rst_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign lock_loss_count = loss_q;
  assign retry_count     = retry_q;

  // State, counters, synchronizer and registered outputs.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      sync_q     <= '0;
      state_q    <= ST_RESET_MMCM;
      cnt_q      <= '0;
      retry_q    <= 3'd0;
      loss_q     <= 8'd0;
      mmcm_rst_q <= 1'b1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], locked_async};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      loss_q     <= loss_d;
      mmcm_rst_q <= mmcm_rst_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  // Next-state logic. Outputs are decoded from the next state so that they
  // change on the same edge as the state register.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_ONE;
    retry_d    = retry_q;
    loss_d     = loss_q;
    mmcm_rst_d = 1'b1;
    sys_rst_d  = 1'b1;
    ready_d    = 1'b0;
    fault_d    = 1'b0;

    case (state_q)
      ST_RESET_MMCM: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          state_d = ST_RESET_MMCM;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock is checked first, so a lock arriving on the timeout cycle wins.
        if (lock_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_q + 3'd1;
          cnt_d   = '0;
          if ((retry_q + 3'd1) == RETRY_LIMIT) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_RESET_MMCM;
          end
        end else begin
          state_d = ST_WAIT_LOCK;
        end
      end
      ST_STABILIZE: begin
        if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = 3'd0;
        end else begin
          state_d = ST_STABILIZE;
        end
      end
      ST_RUN: begin
`ifdef LOCK_DEGLITCH_EN
        // In RUN the counter counts consecutive low cycles of lock_s.
        if (lock_s) begin
          cnt_d = '0;
        end else if (cnt_q == DG_LAST) begin
          loss_d  = sat_inc8(loss_q);
          state_d = ST_RESET_MMCM;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
        end
`else
        if (lock_s) begin
          cnt_d = '0;
        end else begin
          loss_d  = sat_inc8(loss_q);
          state_d = ST_RESET_MMCM;
          cnt_d   = '0;
        end
`endif
      end
      ST_FAULT: begin
        // Terminal until rst. The counter is frozen so that it cannot wrap.
        state_d = ST_FAULT;
        cnt_d   = cnt_q;
      end
      default: begin
        state_d = ST_RESET_MMCM;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      ST_RESET_MMCM: begin
        mmcm_rst_d = 1'b1;
        sys_rst_d  = 1'b1;
      end
      ST_WAIT_LOCK, ST_STABILIZE: begin
        mmcm_rst_d = 1'b0;
        sys_rst_d  = 1'b1;
      end
      ST_RUN: begin
        mmcm_rst_d = 1'b0;
        sys_rst_d  = 1'b0;
        ready_d    = 1'b1;
      end
      ST_FAULT: begin
        mmcm_rst_d = 1'b1;
        sys_rst_d  = 1'b1;
        fault_d    = 1'b1;
      end
      default: begin
        mmcm_rst_d = 1'b1;
        sys_rst_d  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_mmcm_lock_supervisor.sv
// -----------------------------------------------------------------------------
// Testbench for mmcm_lock_supervisor. The reference model tracks the
// supervisor's phase and the time spent in it, and delays the lock input by
// a queue of sampled values. Directed steps cover power-up, retry/fault,
// lock loss, STABILIZE dropout, saturation, mid-count reset and lock on the
// timeout cycle. Random lock and reset traffic follows. Every cycle, every
// output is compared with the model.
// -----------------------------------------------------------------------------
module tb_mmcm_lock_supervisor;

  localparam int SYNC_STAGES     = 2;
  localparam int RST_CYCLES      = 4;
  localparam int LOCK_TIMEOUT    = 50;
  localparam int STABLE_CYCLES   = 20;
  localparam int MAX_RETRIES     = 3;
  localparam int DEGLITCH_CYCLES = 8;
`ifdef LOCK_DEGLITCH_EN
  localparam int LOW_TO_ACT = DEGLITCH_CYCLES;
`else
  localparam int LOW_TO_ACT = 1;
`endif

  // Model phases.
  localparam int P_PULSE = 0, P_WAIT = 1, P_SETTLE = 2, P_RUN = 3, P_FAULT = 4;
  // Output selectors for wait_until.
  localparam int S_MMCM = 0, S_SYS = 1, S_READY = 2, S_FAULT = 3;

  logic       clk_in = 1'b0;
  logic       rst;
  logic       locked_async;
  logic       mmcm_rst, sys_rst, ready, fault;
  logic [7:0] lock_loss_count;
  logic [2:0] retry_count;

  int n_checks = 0;
  int n_fails  = 0;

  int m_phase, m_time, m_low, m_retries, m_losses;
  bit m_pipe[$];

  mmcm_lock_supervisor #(
    .SYNC_STAGES    (SYNC_STAGES),
    .RST_CYCLES     (RST_CYCLES),
    .LOCK_TIMEOUT   (LOCK_TIMEOUT),
    .STABLE_CYCLES  (STABLE_CYCLES),
    .MAX_RETRIES    (MAX_RETRIES),
    .DEGLITCH_CYCLES(DEGLITCH_CYCLES)
  ) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .locked_async   (locked_async),
    .mmcm_rst       (mmcm_rst),
    .sys_rst        (sys_rst),
    .ready          (ready),
    .fault          (fault),
    .lock_loss_count(lock_loss_count),
    .retry_count    (retry_count)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic enter(input int p);
    m_phase = p;
    m_time  = 0;
    m_low   = 0;
  endtask

  // One clock of the reference model. r and a are the rst and locked_async
  // values that were sampled on this edge.
  task automatic model_step(input logic r, input logic a);
    bit ls;
    if (r) begin
      m_pipe.delete();
      repeat (SYNC_STAGES) m_pipe.push_back(1'b0);
      enter(P_PULSE);
      m_retries = 0;
      m_losses  = 0;
    end else begin
      ls = m_pipe.pop_front();
      m_pipe.push_back(a);
      case (m_phase)
        P_PULSE: begin
          m_time++;
          if (m_time == RST_CYCLES) enter(P_WAIT);
        end
        P_WAIT: begin
          if (ls) begin
            enter(P_SETTLE);
          end else begin
            m_time++;
            if (m_time == LOCK_TIMEOUT) begin
              m_retries++;
              enter((m_retries == MAX_RETRIES) ? P_FAULT : P_PULSE);
            end
          end
        end
        P_SETTLE: begin
          if (!ls) begin
            enter(P_WAIT);
          end else begin
            m_time++;
            if (m_time == STABLE_CYCLES) begin
              m_retries = 0;
              enter(P_RUN);
            end
          end
        end
        P_RUN: begin
          if (ls) begin
            m_low = 0;
          end else begin
            m_low++;
            if (m_low >= LOW_TO_ACT) begin
              if (m_losses < 255) m_losses++;
              enter(P_PULSE);
            end
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    check("mmcm_rst", 32'(mmcm_rst), 32'(m_phase == P_PULSE || m_phase == P_FAULT));
    check("sys_rst", 32'(sys_rst), 32'(m_phase != P_RUN));
    check("ready", 32'(ready), 32'(m_phase == P_RUN));
    check("fault", 32'(fault), 32'(m_phase == P_FAULT));
    check("lock_loss_count", 32'(lock_loss_count), 32'(m_losses));
    check("retry_count", 32'(retry_count), 32'(m_retries));
  endtask

  // Advance one clock: step the model with the sampled inputs, then compare
  // the outputs 1 time unit after the edge.
  task automatic tick();
    logic s_rst, s_lock;
    @(posedge clk_in);
    s_rst  = rst;
    s_lock = locked_async;
    model_step(s_rst, s_lock);
    #1;
    check_outputs();
  endtask

  function automatic logic sel(input int which);
    case (which)
      S_MMCM:  return mmcm_rst;
      S_SYS:   return sys_rst;
      S_READY: return ready;
      S_FAULT: return fault;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int which, input logic val, input int bound, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (sel(which) !== val && n < bound);
  endtask

  initial begin
    int   n;
    int   falls;
    int   len;
    logic prev;

    rst          = 1'b1;
    locked_async = 1'b0;
    repeat (3) tick();
    check("reset_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("reset_ready", 32'(ready), 32'd0);

    // 1. Power-up, with lock arriving 10 cycles after the MMCM reset is released.
    rst = 1'b0;
    wait_until(S_MMCM, 1'b0, 100, n);
    check("pwrup_rst_pulse_len", 32'(n), 32'(RST_CYCLES));
    repeat (10) tick();
    locked_async = 1'b1;
    wait_until(S_READY, 1'b1, 200, n);
    check("pwrup_lock_to_ready", 32'(n), 32'(SYNC_STAGES + 1 + STABLE_CYCLES));
    check("pwrup_sys_rst", 32'(sys_rst), 32'd0);
    check("pwrup_retry", 32'(retry_count), 32'd0);

    // 3. Lock loss in RUN.
`ifndef LOCK_DEGLITCH_EN
    locked_async = 1'b0;
    tick();
    locked_async = 1'b1;
    n = 1;
    while (sys_rst !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("loss_to_sys_rst", 32'(n), 32'(SYNC_STAGES + 1));
    check("loss_count_1", 32'(lock_loss_count), 32'd1);
    wait_until(S_MMCM, 1'b0, 40, n);
    check("loss_rst_pulse_len", 32'(n), 32'(RST_CYCLES));
`else
    locked_async = 1'b0;
    repeat (5) tick();
    locked_async = 1'b1;
    repeat (5) tick();
    check("glitch5_ready", 32'(ready), 32'd1);
    check("glitch5_count", 32'(lock_loss_count), 32'd0);
    locked_async = 1'b0;
    repeat (9) tick();
    locked_async = 1'b1;
    wait_until(S_SYS, 1'b1, 20, n);
    check("drop9_sys_rst", 32'(sys_rst), 32'd1);
    check("drop9_count", 32'(lock_loss_count), 32'd1);
`endif
    wait_until(S_READY, 1'b1, 200, n);
    check("loss_relock_ready", 32'(ready), 32'd1);

    // 4. Dropout 10 cycles into STABILIZE restarts the full stable window.
    locked_async = 1'b0;
    wait_until(S_SYS, 1'b1, 40, n);
    wait_until(S_MMCM, 1'b0, 40, n);
    locked_async = 1'b1;
    repeat (SYNC_STAGES + 1 + 10) tick();
    locked_async = 1'b0;
    repeat (3) tick();
    locked_async = 1'b1;
    wait_until(S_READY, 1'b1, 200, n);
    check("stab_dropout_full_window", 32'(n), 32'(SYNC_STAGES + 1 + STABLE_CYCLES));
    check("stab_dropout_retry", 32'(retry_count), 32'd0);

    // 5. Saturation of the lock-loss counter, then rst mid-WAIT_LOCK.
    for (int i = 0; i < 256; i++) begin
      locked_async = 1'b0;
      repeat (10) tick();
      locked_async = 1'b1;
      wait_until(S_READY, 1'b1, 200, n);
    end
    check("sat_count", 32'(lock_loss_count), 32'd255);
    locked_async = 1'b0;
    wait_until(S_MMCM, 1'b1, 40, n);
    wait_until(S_MMCM, 1'b0, 40, n);
    repeat (30) tick();
    rst = 1'b1;
    tick();
    check("midrst_mmcm_rst", 32'(mmcm_rst), 32'd1);
    check("midrst_sys_rst", 32'(sys_rst), 32'd1);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_fault", 32'(fault), 32'd0);
    check("midrst_count", 32'(lock_loss_count), 32'd0);
    check("midrst_retry", 32'(retry_count), 32'd0);

    // 2. Lock never arrives, so the retries run out and the fault latches.
    rst = 1'b0;
    falls = 0;
    prev  = mmcm_rst;
    n     = 0;
    while (fault !== 1'b1 && n < 1000) begin
      tick();
      n++;
      if (prev === 1'b1 && mmcm_rst === 1'b0) falls++;
      prev = mmcm_rst;
    end
    check("timeout_cycles_to_fault", 32'(n), 32'(MAX_RETRIES * (RST_CYCLES + LOCK_TIMEOUT)));
    check("timeout_pulse_count", 32'(falls), 32'(MAX_RETRIES));
    check("timeout_retry", 32'(retry_count), 32'(MAX_RETRIES));
    repeat (100) tick();
    check("fault_sticky", 32'(fault), 32'd1);
    check("fault_sys_rst", 32'(sys_rst), 32'd1);

    // 6. Lock on the final timeout cycle of the second WAIT_LOCK.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_until(S_MMCM, 1'b0, 40, n);
    wait_until(S_MMCM, 1'b1, 100, n);
    check("first_timeout_len", 32'(n), 32'(LOCK_TIMEOUT));
    wait_until(S_MMCM, 1'b0, 40, n);
    repeat (LOCK_TIMEOUT - SYNC_STAGES - 1) tick();
    locked_async = 1'b1;
    repeat (SYNC_STAGES + 1) tick();
    check("edge_lock_no_rst", 32'(mmcm_rst), 32'd0);
    check("edge_lock_retry", 32'(retry_count), 32'd1);
    wait_until(S_READY, 1'b1, 100, n);
    check("edge_lock_to_ready", 32'(n), 32'(STABLE_CYCLES));
    check("edge_lock_retry_clear", 32'(retry_count), 32'd0);

    // Random lock traffic with occasional single-cycle resets.
    for (int seg = 0; seg < 150; seg++) begin
      len          = $urandom_range(1, 70);
      locked_async = ($urandom_range(0, 2) != 0);
      rst          = ($urandom_range(0, 29) == 0);
      for (int k = 0; k < len; k++) begin
        tick();
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mmcm_lock_supervisor.md
Name: mmcm_lock_supervisor

Overview:
Consumes the LOCKED status of the board MMCM that generates the 90/65 MHz fabric clocks, and drives that MMCM's RST input. Runs entirely on the free-running 125 MHz board clock. Sequences MMCM reset, waits for lock with timeout/retry, and holds the downstream system reset until lock has been stable. Counts lock-loss events and raises a sticky fault after repeated lock failures.

Parameters:
SYNC_STAGES, 2, flops in the locked_async synchronizer (min 2)
RST_CYCLES, 16, cycles mmcm_rst is held high per reset pulse (min 1)
LOCK_TIMEOUT, 125000, cycles to wait for lock after mmcm_rst release (1 ms at 125 MHz)
STABLE_CYCLES, 1024, consecutive locked cycles required before releasing sys_rst
MAX_RETRIES, 4, consecutive lock timeouts before entering FAULT
DEGLITCH_CYCLES, 8, lock-low persistence in RUN before acting (only with LOCK_DEGLITCH_EN)

Ports:
clk_in  input  1  125 MHz board clock, free-running, never sourced from the MMCM
rst  input  1  synchronous, active-high reset
locked_async  input  1  MMCM LOCKED, asynchronous to clk_in
mmcm_rst  output  1  MMCM RST request, active high
sys_rst  output  1  downstream system reset, active high
ready  output  1  high only in RUN
fault  output  1  sticky; high in FAULT
lock_loss_count  output  8  lock losses detected in RUN, saturates at 255
retry_count  output  3  consecutive lock timeouts since last successful lock

Behaviour:
- Single clock domain (clk_in). Reset is synchronous and active-high (rst), sampled on the rising edge of clk_in.
- locked_async passes through SYNC_STAGES flops to give lock_s. The FSM uses only lock_s.
- Reset values: mmcm_rst=1, sys_rst=1, ready=0, fault=0, lock_loss_count=0, retry_count=0, synchronizer flops=0, state=RESET_MMCM, cycle counter=0.
- One cycle counter, wide enough for max(LOCK_TIMEOUT, STABLE_CYCLES). It clears on every state transition.
- RESET_MMCM: mmcm_rst=1, sys_rst=1. After exactly RST_CYCLES cycles in this state, go to WAIT_LOCK.
- WAIT_LOCK: mmcm_rst=0, sys_rst=1.
  - lock_s=1: go to STABILIZE.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0: retry_count+1.
  - On that timeout, if the new retry_count equals MAX_RETRIES, go to FAULT; otherwise go to RESET_MMCM.
  - If lock_s rises on the same cycle as the timeout, lock wins and the state goes to STABILIZE.
- STABILIZE: mmcm_rst=0, sys_rst=1.
  - lock_s=0: go to WAIT_LOCK. The counter clears; retry_count is unchanged.
  - STABLE_CYCLES consecutive cycles with lock_s=1: go to RUN and clear retry_count.
- RUN: mmcm_rst=0, sys_rst=0, ready=1. These outputs are registered and take effect the cycle after entry.
  - lock_s=0: in the same transition, lock_loss_count+1 (saturating), sys_rst=1, ready=0, and go to RESET_MMCM.
- FAULT: mmcm_rst=1, sys_rst=1, ready=0, fault=1. Held until rst; no auto-recovery.
- rst asserted in any state, mid-count included: synchronous return to reset values on the next edge, and counters clear.
- Minimum time from rst deassert to ready: RST_CYCLES + SYNC_STAGES + STABLE_CYCLES + ~2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
LOCK_DEGLITCH_EN
- Defined: in RUN, lock_s must stay low for DEGLITCH_CYCLES consecutive cycles before the lock loss is acted on. The deglitch counter clears whenever lock_s=1. Shorter dropouts are ignored and do not increment lock_loss_count.
- Undefined: a single low cycle of lock_s in RUN triggers lock-loss handling. DEGLITCH_CYCLES is unused.

Test Plan:
Bench params: RST_CYCLES=4, LOCK_TIMEOUT=50, STABLE_CYCLES=20, MAX_RETRIES=3, SYNC_STAGES=2.
1. Power-up: rst high 3 cycles; locked_async=1 from 10 cycles after mmcm_rst falls -> mmcm_rst high exactly 4 cycles after rst release; ready=1 and sys_rst=0 exactly 20 cycles after lock_s rises; retry_count=0.
2. Timeout/retry: locked_async held 0 -> three mmcm_rst pulses of 4 cycles, spaced 50 cycles of WAIT_LOCK; retry_count goes 1,2,3; fault=1 after the 3rd timeout and stays high; sys_rst=1 throughout.
3. Lock loss in RUN: after ready=1, drop locked_async 1 cycle (no macro) -> sys_rst=1 within 3 cycles; lock_loss_count=1; mmcm_rst pulses 4 cycles; re-lock returns ready=1. With LOCK_DEGLITCH_EN and DEGLITCH_CYCLES=8: a 5-cycle drop leaves ready=1 and count=0; a 9-cycle drop sets count=1.
4. STABILIZE dropout: lock at cycle 0, drop at cycle 10 of STABILIZE -> back to WAIT_LOCK; sys_rst stays 1; retry_count unchanged; a full 20-cycle stable window is required again.
5. Saturation and reset: force 256 lock losses -> lock_loss_count=255; rst mid-WAIT_LOCK (counter at 30) -> all outputs at reset values next cycle, count=0.
6. Lock on timeout cycle: lock_s rises on counter=49 -> STABILIZE entered; retry_count not incremented.
